// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage; stalls the pipe while an access runs.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mem_stall
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  if (DEPTH != (32'd1 << ADDR_W)) begin : gen_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : gen_bad_latency
    $error("LATENCY must be in 1..15");
  end

  localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } stateT;

  stateT              stateQ, stateD;
  logic [3:0]         cntQ, cntD;
  logic [ADDR_W-1:0]  idxQ;
  logic [31:0]        wdataQ;
  logic               isWriteQ;

  logic               req;
  logic               accept;
  logic               commit;
  logic [ADDR_W-1:0]  accIdx;
  logic [31:0]        accData;
  logic               accWrite;
  logic               accMis;

  logic [31:0]        mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  logic               misQ;
  logic               unusedAddrBits;
  assign unusedAddrBits = ^addr[31:ADDR_W+2];
`else
  logic               unusedAddrBits;
  assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

  assign req = MemRead | MemWrite;

  // With LATENCY=1 the commit edge is also the accept edge, so bypass the latches.
  assign accIdx   = accept ? addr[ADDR_W+1:2] : idxQ;
  assign accData  = accept ? wdata : wdataQ;
  assign accWrite = accept ? MemWrite : isWriteQ;
`ifdef DMEM_ALIGN_CHECK_EN
  assign accMis   = accept ? (addr[1:0] != 2'b00) : misQ;
`else
  assign accMis   = 1'b0;
`endif

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    mem_stall = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (req) begin
          mem_stall = 1'b1;
          accept    = 1'b1;
          if (LATENCY == 1) begin
            stateD = StDone;
            commit = 1'b1;
          end else begin
            cntD   = CntInit;
            stateD = StBusy;
          end
        end
      end
      StBusy: begin
        mem_stall = 1'b1;
        if (cntQ != 4'd0) begin
          cntD = cntQ - 4'd1;
        end else begin
          stateD = StDone;
          commit = 1'b1;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      rdata  <= 32'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (commit && !accWrite) begin
        rdata <= accMis ? 32'd0 : mem[accIdx];
      end
    end
  end

  // Request latches carry no reset; they are only read after an accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      idxQ     <= addr[ADDR_W+1:2];
      wdataQ   <= wdata;
      isWriteQ <= MemWrite;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      misQ <= 1'b0;
    end else if (accept) begin
      misQ <= (addr[1:0] != 2'b00);
    end
  end
  assign misaligned = (stateQ == StDone) && misQ;
`endif

  // Reset wins over a commit so an interrupted store never reaches the array.
  always_ff @(posedge clock) begin
    if (!reset && commit && accWrite && !accMis) begin
      mem[accIdx] <= accData;
    end
  end

  assign rdata_valid = (stateQ == StDone) && !isWriteQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; define DMEM_ALIGN_CHECK_EN to cover the alignment check.
module tb_data_mem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int nVectors     = 0;
  int nMiscompares = 0;

  data_mem_responder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LATENCY(LATENCY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .mem_stall  (mem_stall)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access from IDLE through DONE and back to IDLE; inputs are scrambled while busy.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expData);
    logic expValid;
    logic expMis;
    expValid = rd & ~wr;
`ifdef DMEM_ALIGN_CHECK_EN
    expMis = (a[1:0] != 2'b00);
`else
    expMis = 1'b0;
`endif
    @(negedge clock);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    #1;
    check({tag, "/stall_accept"}, 32'(mem_stall), 32'd1);
    @(negedge clock);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = ~a;
    wdata    = ~d;
    for (int i = 1; i < int'(LATENCY); i++) begin
      #1;
      check({tag, "/stall_busy"}, 32'(mem_stall), 32'd1);
      check({tag, "/valid_busy"}, 32'(rdata_valid), 32'd0);
      @(negedge clock);
    end
    #1;
    check({tag, "/stall_done"}, 32'(mem_stall), 32'd0);
    check({tag, "/valid_done"}, 32'(rdata_valid), 32'(expValid));
    check({tag, "/rdata_done"}, rdata, expData);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "/mis_done"}, 32'(misaligned), 32'(expMis));
`endif
    @(negedge clock);
    #1;
    check({tag, "/stall_idle"}, 32'(mem_stall), 32'd0);
    check({tag, "/valid_idle"}, 32'(rdata_valid), 32'd0);
    check({tag, "/rdata_hold"}, rdata, expData);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "/mis_idle"}, 32'(misaligned), 32'd0);
`endif
    if (expMis && !expValid) begin
      // nothing extra: a suppressed store is observed by a later load
    end
  endtask

  initial begin
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = 32'd0;
    wdata    = 32'd0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("reset/rdata", rdata, 32'd0);
    check("reset/valid", 32'(rdata_valid), 32'd0);
    check("reset/stall", 32'(mem_stall), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("reset/mis", 32'(misaligned), 32'd0);
`endif
    reset = 1'b0;

    access("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0);
    access("lw10", 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);

`ifdef DMEM_ALIGN_CHECK_EN
    access("lw11", 1'b1, 1'b0, 32'h11, 32'd0, 32'd0);
    access("sw12", 1'b0, 1'b1, 32'h12, 32'h99, 32'd0);
    access("lw10b", 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
`else
    access("lw13", 1'b1, 1'b0, 32'h13, 32'd0, 32'hDEADBEEF);
`endif

    access("rw20", 1'b1, 1'b1, 32'h20, 32'h5, 32'hDEADBEEF);
    access("lw20", 1'b1, 1'b0, 32'h20, 32'd0, 32'h5);

    access("sw7fc", 1'b0, 1'b1, 32'h3FC + DEPTH * 4, 32'h77, 32'h5);
    access("lw3fc", 1'b1, 1'b0, 32'h3FC, 32'd0, 32'h77);

    access("sw40", 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 32'h77);
    access("lw40", 1'b1, 1'b0, 32'h40, 32'd0, 32'hCAFEF00D);

    access("sw30", 1'b0, 1'b1, 32'h30, 32'hAAAA5555, 32'hCAFEF00D);
    @(negedge clock);
    MemWrite = 1'b1;
    addr     = 32'h30;
    wdata    = 32'h1234;
    #1;
    check("abort/stall_accept", 32'(mem_stall), 32'd1);
    @(negedge clock);
    MemWrite = 1'b0;
    #1;
    check("abort/stall_busy", 32'(mem_stall), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("abort/stall_after_reset", 32'(mem_stall), 32'd0);
    check("abort/rdata_after_reset", rdata, 32'd0);
    check("abort/valid_after_reset", 32'(rdata_valid), 32'd0);
    reset = 1'b0;
    access("lw30", 1'b1, 1'b0, 32'h30, 32'd0, 32'hAAAA5555);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory responder for the MEM pipe stage.
- Services the MemRead/MemWrite requests that the main control generates for LW/SW.
- Freezes the pipeline through mem_stall while an access is outstanding.
- Word-addressed synchronous array with a configurable access latency. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of 2).
- ADDR_W, 8, word-index width; must equal log2(DEPTH).
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  read request from EX/MEM register
- MemWrite  input  1  write request from EX/MEM register
- addr  input  32  byte address (ALU result); word index = addr[ADDR_W+1:2]
- wdata  input  32  store data (forwarded rt value)
- rdata  output  32  load data to MEM/WB register
- rdata_valid  output  1  high for exactly one cycle when rdata holds a completed load
- mem_stall  output  1  pipeline freeze: drives PCWrite/IFID_Write low and holds ID/EX and EX/MEM
- misaligned  output  1  present only with DMEM_ALIGN_CHECK_EN; see below

Behaviour:
Reset and request definition:
- Reset, synchronous and active-high: state=IDLE, cnt=0, rdata=0, rdata_valid=0, misaligned=0. The array is not cleared.
- req = MemRead | MemWrite.
- Write has priority: if both are high, a write is performed and rdata_valid does not pulse.

FSM states: IDLE, BUSY, DONE.
- IDLE, req=0: mem_stall=0; stay in IDLE.
- IDLE, req=1: mem_stall=1 combinationally in the same cycle; latch addr, wdata and op.
  - If LATENCY=1, go to DONE.
  - Otherwise load cnt=LATENCY-2 and go to BUSY.
- BUSY: mem_stall=1.
  - If cnt!=0: decrement cnt and stay in BUSY.
  - If cnt==0: go to DONE.
- Access commit: the access is performed on the clock edge that enters DONE.
  - Write: mem[idx] <= latched wdata.
  - Read: rdata <= mem[idx].
- DONE: mem_stall=0, so the pipeline advances on this edge.
  - rdata_valid=1 for a read, 0 for a write.
  - Request inputs are ignored in DONE; go to IDLE unconditionally.

Timing and data rules:
- Stall length: a request first seen in cycle t stalls cycles t..t+LATENCY-1. rdata is valid in cycle t+LATENCY.
- rdata holds its last value until the next completed read or reset.
- Back-to-back accesses: a new request is accepted only in IDLE, so consecutive LW/SW incur one DONE cycle each, with no overlap.
- Inputs are sampled only at acceptance. Changes during BUSY have no effect.
- Address wrap: addr bits above ADDR_W+1 are ignored, so an index wraps modulo DEPTH. addr[1:0] is ignored unless the alignment check is enabled.
- Reset mid-operation: the FSM returns to IDLE, a pending write is discarded (the array is unchanged), and mem_stall drops in the cycle after reset asserts.
- Read-after-write to the same word in consecutive accesses returns the new data.
- No combinational path from addr or wdata to rdata.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - The misaligned port exists.
  - A request accepted with addr[1:0]!=0 still runs the full LATENCY stall, but in DONE:
    - a write is suppressed (array unchanged);
    - a read returns rdata=0 with rdata_valid=1;
    - misaligned=1 for that DONE cycle only.
  - misaligned is 0 in every other cycle.
- Undefined:
  - The misaligned port is absent.
  - addr[1:0] is ignored and all accesses proceed normally.

Test Plan:
1. Reset, then SW addr=0x10 wdata=0xDEADBEEF with LATENCY=2 -> mem_stall high for 2 cycles, then DONE with rdata_valid=0, and mem[4]=0xDEADBEEF.
2. LW addr=0x10 right after case 1 -> mem_stall high for 2 cycles, then rdata=0xDEADBEEF with rdata_valid high for exactly 1 cycle.
3. MemRead=MemWrite=1, addr=0x20, wdata=0x5 -> write performed (mem[8]=5), rdata_valid stays 0; a later LW 0x20 returns 0x5.
4. SW addr=0x3FC+DEPTH*4 wdata=0x77 with DEPTH=256 -> wraps to index 255; LW 0x3FC returns 0x77.
5. SW addr=0x30 wdata=0x1234, reset asserted in the first BUSY cycle -> FSM returns to IDLE, mem_stall=0 and rdata=0 after the reset edge; LW 0x30 returns the prior contents, not 0x1234.
6. With DMEM_ALIGN_CHECK_EN, LW addr=0x11 -> after LATENCY stalls, rdata=0, rdata_valid=1, misaligned=1 for one cycle; SW addr=0x12 leaves mem[4] unchanged.
